// File: rtl/mem_imm_pkg.sv
// Shared opcode constants and enums for the memory/ALU immediate aligner.
package mem_imm_pkg;

    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_LH   = 6'b100001;
    localparam logic [5:0] OP_LHU  = 6'b100101;
    localparam logic [5:0] OP_SH   = 6'b101001;
    localparam logic [5:0] OP_LB   = 6'b100000;
    localparam logic [5:0] OP_LBU  = 6'b100100;
    localparam logic [5:0] OP_SB   = 6'b101000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_LUI  = 6'b001111;

    typedef enum logic [1:0] {EXT_SIGN, EXT_ZERO, EXT_LUI} ext_mode_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_t;

endpackage

// File: rtl/mem_imm_aligner_if.sv
// Decode-side input and operand-mux-side output handshake bundle.
interface mem_imm_aligner_if #(
    parameter int IMM_W = 16,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
);
    logic [5:0]       opcode;
    logic [IMM_W-1:0] imm_in;
    logic             in_valid;
    logic             in_ready;
    logic [OUT_W-1:0] imm_out;
    logic             misaligned;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] misalign_count;

    modport master (
        output opcode, imm_in, in_valid, out_ready,
        input  in_ready, imm_out, misaligned, out_valid, misalign_count
    );

    modport slave (
        input  opcode, imm_in, in_valid, out_ready,
        output in_ready, imm_out, misaligned, out_valid, misalign_count
    );
endinterface

// File: rtl/mem_imm_decode.sv
// Combinational opcode decode, immediate extension and access-size scaling.
module mem_imm_decode
    import mem_imm_pkg::*;
#(
    parameter int IMM_W      = 16,
    parameter int OUT_W      = 32,
    parameter int WORD_SHIFT = 2,
    parameter int SH_W       = 2
) (
    input  logic [5:0]       opcode,
    input  logic [IMM_W-1:0] imm_in,
    output logic [SH_W-1:0]  shamt,
    output ext_mode_t        ext_mode,
    output logic [OUT_W-1:0] value,
    output logic             misaligned
);
    logic signed [OUT_W-1:0] sx;
    logic        [OUT_W-1:0] zx;

    always_comb begin
        shamt    = '0;
        ext_mode = EXT_SIGN;
        case (opcode)
            OP_LW, OP_SW:           shamt = SH_W'(WORD_SHIFT);
            OP_LH, OP_LHU, OP_SH:   shamt = SH_W'(WORD_SHIFT - 1);
            OP_LB, OP_LBU, OP_SB:   shamt = '0;
            OP_ANDI, OP_ORI, OP_XORI: ext_mode = EXT_ZERO;
            OP_LUI:                 ext_mode = EXT_LUI;
            default:                shamt = '0;
        endcase
    end

    always_comb begin
        sx    = OUT_W'($signed(imm_in));
        zx    = OUT_W'(imm_in);
        value = '0;
        case (ext_mode)
            EXT_ZERO: value = zx >> shamt;
            EXT_LUI:  value = zx << (OUT_W - IMM_W);
            default:  value = OUT_W'(sx >>> shamt);
        endcase
    end

    // Any set bit below the shift amount is lost by the scaling.
    always_comb begin
        misaligned = 1'b0;
        for (int unsigned i = 0; i < WORD_SHIFT; i++) begin
            if (i < 32'(shamt) && imm_in[i]) misaligned = 1'b1;
        end
    end

endmodule

// File: rtl/mem_imm_aligner.sv
// Immediate aligner: decode stage feeding a 2-entry valid/ready skid buffer.
// Optional MISALIGN_CNT_EN adds a saturating counter of misaligned accepts.
module mem_imm_aligner
    import mem_imm_pkg::*;
#(
    parameter int IMM_W      = 16,
    parameter int OUT_W      = 32,
    parameter int WORD_SHIFT = 2,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic rst_n,
    mem_imm_aligner_if.slave bus
);
    localparam int SH_W = $clog2(WORD_SHIFT + 1);

    logic [SH_W-1:0]  dec_shamt;
    ext_mode_t        dec_mode;
    logic [OUT_W-1:0] dec_value;
    logic             dec_mis;

    mem_imm_decode #(
        .IMM_W      (IMM_W),
        .OUT_W      (OUT_W),
        .WORD_SHIFT (WORD_SHIFT),
        .SH_W       (SH_W)
    ) u_decode (
        .opcode     (bus.opcode),
        .imm_in     (bus.imm_in),
        .shamt      (dec_shamt),
        .ext_mode   (dec_mode),
        .value      (dec_value),
        .misaligned (dec_mis)
    );

    logic unused_dec;
    assign unused_dec = ^{dec_shamt, dec_mode};

    skid_state_t      state;
    logic [OUT_W-1:0] main_val, skid_val;
    logic             main_mis, skid_mis;
    logic             in_ready, out_valid, accept, consume;

    // Handshake flags come from state only, so out_ready never reaches in_ready.
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = bus.in_valid && in_ready;
    assign consume   = out_valid && bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            main_val <= '0;
            main_mis <= 1'b0;
            skid_val <= '0;
            skid_mis <= 1'b0;
        end else begin
            case (state)
                EMPTY: if (accept) begin
                    main_val <= dec_value;
                    main_mis <= dec_mis;
                    state    <= ONE;
                end
                ONE: if (accept && consume) begin
                    main_val <= dec_value;
                    main_mis <= dec_mis;
                end else if (accept) begin
                    skid_val <= dec_value;
                    skid_mis <= dec_mis;
                    state    <= TWO;
                end else if (consume) begin
                    state <= EMPTY;
                end
                TWO: if (consume) begin
                    main_val <= skid_val;
                    main_mis <= skid_mis;
                    state    <= ONE;
                end
                default: state <= EMPTY;
            endcase
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid;
    assign bus.imm_out    = main_val;
    assign bus.misaligned = main_mis;

`ifdef MISALIGN_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.misalign_count <= '0;
        end else if (accept && dec_mis && bus.misalign_count != '1) begin
            bus.misalign_count <= bus.misalign_count + CNT_W'(1);
        end
    end
`else
    assign bus.misalign_count = '0;
`endif

endmodule

// File: doc/mem_imm_aligner.md
Name: mem_imm_aligner

Overview:
- Parametrised successor to the lw/sw immediate divider in the MIPS datapath. It decodes the opcode, extends the 16-bit immediate, and scales it by access size: word by 4, halfword by 2, byte by 1.
- It also sign- or zero-extends ALU immediates, forms the LUI value, and flags low-order bits lost to scaling.
- Output is registered behind a 2-entry valid/ready skid buffer. It sits between instruction decode and the address/ALU-operand mux.

Parameters:
- IMM_W, 16, immediate field width.
- OUT_W, 32, output operand width; OUT_W >= IMM_W.
- WORD_SHIFT, 2, log2 of the word byte size. Halfword shift is WORD_SHIFT-1, byte shift is 0. WORD_SHIFT >= 1.
- CNT_W, 16, width of the misalignment counter.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  instruction bits [31:26].
- imm_in  in  IMM_W  instruction bits [15:0].
- in_valid  in  1  opcode/imm_in valid.
- in_ready  out  1  block can accept an input.
- imm_out  out  OUT_W  processed immediate.
- misaligned  out  1  nonzero bits were discarded by scaling for this output.
- out_valid  out  1  imm_out/misaligned valid.
- out_ready  in  1  consumer accepts.
- misalign_count  out  CNT_W  saturating count of misaligned inputs accepted.

Behaviour:
- Decode to a shift amount s and an extension mode:
  - Word (s = WORD_SHIFT, sign-extend): lw 100011, sw 101011.
  - Half (s = WORD_SHIFT-1, sign-extend): lh 100001, lhu 100101, sh 101001.
  - Byte (s = 0, sign-extend): lb 100000, lbu 100100, sb 101000.
  - Zero-extend, s = 0: andi 001100, ori 001101, xori 001110.
  - LUI 001111: imm_in placed in the upper bits, i.e. zero-extended imm_in << (OUT_W-IMM_W); 0x00010000 for imm_in = 0x0001 with defaults.
  - All other opcodes: sign-extend, s = 0.
- Arithmetic:
  - Sign-extend imm_in to OUT_W, then arithmetic right shift by s; the sign is preserved.
  - Zero-extend modes shift logically.
- misaligned = 1 iff s > 0 and imm_in[s-1:0] != 0. The result is still produced (truncated toward -inf).
- Handshake:
  - An input is accepted when in_valid && in_ready.
  - An output is consumed when out_valid && out_ready.
  - Latency is 1 cycle from accept to out_valid when the buffer is empty.
  - While out_valid && !out_ready, imm_out and misaligned hold stable.
  - No combinational path from out_ready to in_ready.
- FSM with states EMPTY, ONE, TWO:
  - in_ready = (state != TWO).
  - out_valid = (state != EMPTY).
- FSM transitions:
  - EMPTY, accept -> ONE; the main register loads the processed value.
  - ONE, accept and consume -> ONE; the main register loads the new value.
  - ONE, accept without consume -> TWO; the skid register loads the new value.
  - ONE, consume without accept -> EMPTY.
  - TWO, consume -> ONE; skid moves to main. in_valid is ignored in TWO.
  - Otherwise, hold.
- Reset, asynchronous, any time including mid-transfer: state = EMPTY, imm_out = 0, misaligned = 0, out_valid = 0, misalign_count = 0. in_ready is 1 after reset. Buffered data is discarded.
- Data order is strictly FIFO; no drops, no duplicates.

Optional Feature:
- MISALIGN_CNT_EN defined:
  - misalign_count increments by 1 on each accepted input whose computed misaligned = 1.
  - It saturates at 2^CNT_W-1 and is cleared only by reset.
- Not defined: misalign_count tied to 0 and the counter logic is omitted.

Decomposition:
- Shared package mem_imm_pkg holds:
  - Opcode localparams: OP_LW, OP_SW, OP_LH, OP_LHU, OP_SH, OP_LB, OP_LBU, OP_SB, OP_ANDI, OP_ORI, OP_XORI, OP_LUI.
  - Enum ext_mode_t: EXT_SIGN, EXT_ZERO, EXT_LUI.
  - Enum skid_state_t: EMPTY, ONE, TWO.
- One combinational sub-module, mem_imm_decode: opcode and imm_in in; shift amount, ext_mode, processed value and misaligned out. It is instantiated once ahead of the skid buffer.

Test Plan:
- Reset, then lw with imm 0x0010, out_ready = 1 -> next cycle out_valid = 1, imm_out = 0x00000004, misaligned = 0.
- sw with imm 0xFFF8 -> imm_out 0xFFFFFFFE. lh with imm 0x0006 -> imm_out 0x00000003. lw with imm 0x0013 -> imm_out 0x00000004, misaligned = 1, and misalign_count = 1 when MISALIGN_CNT_EN is defined.
- ori with imm 0x8001 -> imm_out 0x00008001. addi (001000) with imm 0x8001 -> 0xFFFF8001. lui with imm 0x1234 -> 0x12340000.
- Hold out_ready = 0 and send 3 back-to-back inputs -> in_ready drops after the 2nd accept and the 3rd waits. Output stays stable. Releasing out_ready drains in order with no loss.
- Random in_valid/out_ready over 1000 cycles -> output sequence matches a reference model. No output while out_valid = 0.
- Assert rst_n = 0 in state TWO -> outputs are 0 immediately (asynchronous), in_ready = 1 after release, and the old data never appears.
